delay_stall_unit: RTL

// Parametrised stall generator for the DELAY instruction (opcode 5'b11111, 27-bit unit count in [26:0]).

---
 rtl/delay_stall_unit.sv | 126 ++++++++++++
 1 files changed

// File: rtl/delay_stall_unit.sv
// Stall generator for DELAY: freezes PC/F-D for units*PRESCALE cycles, then releases once.
// Latency: stall is combinational on the detection cycle; done/busy/units_left are registered.
// Backpressure: counting ignores hold; RELEASE waits for hold=0 before returning to IDLE.
module delay_stall_unit #(
    parameter logic [4:0] DELAY_OPCODE = 5'b11111,
    parameter int         ARG_W        = 27,
    parameter int         PRESCALE     = 100000,
    parameter int         MAX_UNITS    = 2**20-1,
    parameter int         UNIT_W       = 20,
    parameter int         PRE_W        = 17
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       fd_ir,
    input  logic              fd_valid,
    input  logic              hold,
    input  logic              flush,
    output logic              stall,
    output logic              busy,
    output logic              done,
    output logic [UNIT_W-1:0] units_left
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COUNT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam bit               PRE_ONE     = (PRESCALE == 1);
    localparam int               PRE_FIRST_I = (PRESCALE > 1) ? PRESCALE - 2 : 0;
    localparam logic [PRE_W-1:0] PRE_FIRST   = PRE_W'(PRE_FIRST_I);
    localparam logic [PRE_W-1:0] PRE_LAST    = PRE_W'(PRESCALE - 1);
    localparam logic [ARG_W-1:0] MAX_ARG     = ARG_W'(MAX_UNITS);

    state_t            state_q, state_d;
    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [UNIT_W-1:0] units_q, units_d;
    logic              done_d;
    logic              hit;
    logic [ARG_W-1:0]  arg_raw;
    logic [UNIT_W-1:0] arg_units;

    assign arg_raw   = fd_ir[ARG_W-1:0];
    assign arg_units = (arg_raw > MAX_ARG) ? UNIT_W'(MAX_UNITS) : UNIT_W'(arg_raw);
    assign hit       = fd_valid && (fd_ir[31:27] == DELAY_OPCODE) && !flush;

    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        units_d = units_q;
        done_d  = 1'b0;
        stall   = 1'b0;
        case (state_q)
            IDLE: begin
                if (hit) begin
                    if (arg_units == '0) begin
                        done_d = 1'b1;
                    end else begin
                        stall = 1'b1;
                        // The detection cycle already consumed one prescale tick.
                        if (PRE_ONE && arg_units == UNIT_W'(1)) begin
                            state_d = RELEASE;
                            units_d = '0;
                            done_d  = 1'b1;
                        end else begin
                            state_d = COUNT;
                            units_d = PRE_ONE ? arg_units - UNIT_W'(1) : arg_units;
                            pre_d   = PRE_FIRST;
                        end
                    end
                end
            end
            COUNT: begin
                stall = !flush;
                if (flush) begin
                    state_d = IDLE;
                    units_d = '0;
                    pre_d   = '0;
                end else if (pre_q == '0) begin
                    if (units_q == UNIT_W'(1)) begin
                        state_d = RELEASE;
                        units_d = '0;
                        done_d  = 1'b1;
                    end else begin
                        units_d = units_q - UNIT_W'(1);
                        pre_d   = PRE_LAST;
                    end
                end else begin
                    pre_d = pre_q - PRE_W'(1);
                end
            end
            RELEASE: begin
                // fd_ir still holds the finished DELAY here; never re-trigger on it.
                if (flush || !hold) begin
                    state_d = IDLE;
                    units_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                units_d = '0;
                pre_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            pre_q   <= '0;
            units_q <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            units_q <= units_d;
            busy    <= (state_d == COUNT);
            done    <= done_d;
        end
    end

    assign units_left = units_q;

endmodule
